// File: rtl/ex_muldiv_seq_if.sv
// EX-stage request/response bundle for the sequential multiply/divide unit.
// master = EX stage driving operands, slave = the muldiv block.
interface ex_muldiv_seq_if;
    logic        start;
    logic        op;
    logic        abort;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        div_zero;

    modport master (
        output start, op, abort, op_a, op_b,
        input  busy, stall, done, result_lo, result_hi, div_zero
    );

    modport slave (
        input  start, op, abort, op_a, op_b,
        output busy, stall, done, result_lo, result_hi, div_zero
    );
endinterface

// File: rtl/ex_muldiv_seq.sv
// Sequential 32x32 unsigned shift-add multiplier / restoring divider, one bit per cycle.
// The divider is present only when MULDIV_DIV_EN is defined.
module ex_muldiv_seq (
    input  logic          clk,
    input  logic          rst_n,
    ex_muldiv_seq_if.slave bus_io
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic        dz_q, dz_d;
    logic        accept;

    // {hi, lo} is the partial product; lo starts as the multiplier and shifts out LSB first.
    logic [32:0] sum;
    logic [31:0] mul_hi, mul_lo;
    logic [31:0] iter_hi, iter_lo;

    assign sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_hi = sum[32:1];
    assign mul_lo = {sum[0], lo_q[31:1]};

`ifdef MULDIV_DIV_EN
    logic        op_q, op_d;
    logic [32:0] trial;
    logic [31:0] div_hi, div_lo;

    // hi holds the partial remainder, lo shifts the dividend out and the quotient in.
    assign trial   = {hi_q, lo_q[31]} - {1'b0, opnd_q};
    assign div_hi  = trial[32] ? {hi_q[30:0], lo_q[31]} : trial[31:0];
    assign div_lo  = {lo_q[30:0], ~trial[32]};
    assign iter_hi = op_q ? div_hi : mul_hi;
    assign iter_lo = op_q ? div_lo : mul_lo;
`else
    assign iter_hi = mul_hi;
    assign iter_lo = mul_lo;
`endif

    assign accept = (state_q == IDLE) && bus_io.start && !bus_io.abort;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        dz_d     = dz_q;
`ifdef MULDIV_DIV_EN
        op_d     = op_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = 6'd0;
                    hi_d    = 32'd0;
                    state_d = RUN;
                    opnd_d  = bus_io.op_a;
                    lo_d    = bus_io.op_b;
`ifdef MULDIV_DIV_EN
                    op_d = bus_io.op;
                    if (bus_io.op) begin
                        opnd_d = bus_io.op_b;
                        lo_d   = bus_io.op_a;
                        if (bus_io.op_b == 32'd0) begin
                            state_d  = DONE;
                            res_lo_d = 32'hFFFF_FFFF;
                            res_hi_d = bus_io.op_a;
                            dz_d     = 1'b1;
                        end
                    end
`else
                    if (bus_io.op) begin
                        state_d  = DONE;
                        res_lo_d = 32'd0;
                        res_hi_d = 32'd0;
                        dz_d     = 1'b0;
                    end
`endif
                end
            end
            RUN: begin
                if (bus_io.abort) begin
                    state_d = IDLE;
                end else begin
                    hi_d = iter_hi;
                    lo_d = iter_lo;
                    if (cnt_q == 6'd31) begin
                        state_d  = DONE;
                        res_lo_d = iter_lo;
                        res_hi_d = iter_hi;
                        dz_d     = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            opnd_q   <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            res_lo_q <= 32'd0;
            res_hi_q <= 32'd0;
            dz_q     <= 1'b0;
`ifdef MULDIV_DIV_EN
            op_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            dz_q     <= dz_d;
`ifdef MULDIV_DIV_EN
            op_q     <= op_d;
`endif
        end
    end

    assign bus_io.busy      = (state_q != IDLE);
    assign bus_io.stall     = accept || (state_q == RUN);
    assign bus_io.done      = (state_q == DONE);
    assign bus_io.result_lo = res_lo_q;
    assign bus_io.result_hi = res_hi_q;
    assign bus_io.div_zero  = dz_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: directed cases plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_ex_muldiv_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_muldiv_seq_if bus ();

    ex_muldiv_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

`ifdef MULDIV_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 computing, 2 result presented.
    int          m_phase = 0;
    int          m_left  = 0;
    logic [31:0] m_lo = '0, m_hi = '0, p_lo = '0, p_hi = '0;
    logic        m_dz = 1'b0, p_dz = 1'b0;
    logic [63:0] prod;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_left = 0; m_lo = '0; m_hi = '0; m_dz = 1'b0;
        end else begin
            case (m_phase)
                0: if (bus.start && !bus.abort) begin
                    if (bus.op) begin
`ifdef MULDIV_DIV_EN
                        if (bus.op_b == 32'd0) begin
                            m_lo = 32'hFFFF_FFFF; m_hi = bus.op_a; m_dz = 1'b1; m_phase = 2;
                        end else begin
                            p_lo = bus.op_a / bus.op_b; p_hi = bus.op_a % bus.op_b; p_dz = 1'b0;
                            m_phase = 1; m_left = 32;
                        end
`else
                        m_lo = '0; m_hi = '0; m_dz = 1'b0; m_phase = 2;
`endif
                    end else begin
                        prod = 64'(bus.op_a) * 64'(bus.op_b);
                        p_lo = prod[31:0]; p_hi = prod[63:32]; p_dz = 1'b0;
                        m_phase = 1; m_left = 32;
                    end
                end
                1: if (bus.abort) begin
                    m_phase = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_lo = p_lo; m_hi = p_hi; m_dz = p_dz; m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("busy",   64'(bus.busy),  64'(m_phase != 0));
            check("stall",  64'(bus.stall),
                  64'((m_phase == 0 && bus.start && !bus.abort) || m_phase == 1));
            check("done",   64'(bus.done),  64'(m_phase == 2));
            check("res_lo", 64'(bus.result_lo), 64'(m_lo));
            check("res_hi", 64'(bus.result_hi), 64'(m_hi));
            check("div_zero", 64'(bus.div_zero), 64'(m_dz));
        end
    end

    // Issue one operation, scramble operands after acceptance, wait for done.
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int stalls);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = o; bus.op_a = a; bus.op_b = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = ~o; bus.op_a = $urandom; bus.op_b = $urandom;
        lat = 0; stalls = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.stall) stalls++;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) check("done_timeout", 64'(0), 64'(1));
    endtask

    int lat, stalls, pulses, last;
    int exp_div_lat;

    initial begin
        exp_div_lat = DivEn ? 33 : 1;
        bus.start = 1'b0; bus.op = 1'b0; bus.abort = 1'b0; bus.op_a = '0; bus.op_b = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  64'(bus.busy),  64'(0));
        check("rst_stall", 64'(bus.stall), 64'(0));
        check("rst_done",  64'(bus.done),  64'(0));
        check("rst_lo",    64'(bus.result_lo), 64'(0));
        check("rst_hi",    64'(bus.result_hi), 64'(0));
        check("rst_dz",    64'(bus.div_zero),  64'(0));
        rst_n = 1'b1;
        chk_en = 1'b1;

        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, stalls);
        check("mulmax_lat",   64'(lat), 64'(33));
        check("mulmax_stall", 64'(stalls), 64'(32));
        check("mulmax_hi",    64'(bus.result_hi), 64'h0000_0000_FFFF_FFFE);
        check("mulmax_lo",    64'(bus.result_lo), 64'h1);

        run_op(1'b0, 32'd6, 32'd7, lat, stalls);
        check("mul67_lo", 64'(bus.result_lo), 64'd42);
        check("mul67_hi", 64'(bus.result_hi), 64'd0);

        run_op(1'b1, 32'd100, 32'd7, lat, stalls);
        check("div100_7_lat", 64'(lat), 64'(exp_div_lat));
        check("div100_7_lo",  64'(bus.result_lo), DivEn ? 64'd14 : 64'd0);
        check("div100_7_hi",  64'(bus.result_hi), DivEn ? 64'd2 : 64'd0);
        check("div100_7_dz",  64'(bus.div_zero),  64'd0);

        run_op(1'b1, 32'd5, 32'd0, lat, stalls);
        check("div5_0_lat", 64'(lat), 64'd1);
        check("div5_0_lo",  64'(bus.result_lo), DivEn ? 64'hFFFF_FFFF : 64'd0);
        check("div5_0_hi",  64'(bus.result_hi), DivEn ? 64'd5 : 64'd0);
        check("div5_0_dz",  64'(bus.div_zero),  DivEn ? 64'd1 : 64'd0);

        // Abort mid-run: no done, results unchanged
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 1'b0; bus.op_a = 32'd3; bus.op_b = 32'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("abort_no_done", 64'(pulses), 64'd0);
        check("abort_busy",    64'(bus.busy), 64'd0);
        check("abort_hold_lo", 64'(bus.result_lo), DivEn ? 64'hFFFF_FFFF : 64'd0);
        check("abort_hold_hi", 64'(bus.result_hi), DivEn ? 64'd5 : 64'd0);
        run_op(1'b0, 32'd2, 32'd2, lat, stalls);
        check("mul22_lo", 64'(bus.result_lo), 64'd4);
        check("mul22_dz", 64'(bus.div_zero),  64'd0);

        // Reset mid-operation
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = DivEn; bus.op_a = 32'd100; bus.op_b = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy",  64'(bus.busy),  64'd0);
        check("midrst_stall", 64'(bus.stall), 64'd0);
        check("midrst_done",  64'(bus.done),  64'd0);
        check("midrst_lo",    64'(bus.result_lo), 64'd0);
        check("midrst_hi",    64'(bus.result_hi), 64'd0);
        check("midrst_dz",    64'(bus.div_zero),  64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        run_op(1'b1, 32'd9, 32'd3, lat, stalls);
        check("div9_3_lat", 64'(lat), 64'(exp_div_lat));
        check("div9_3_lo",  64'(bus.result_lo), DivEn ? 64'd3 : 64'd0);
        check("div9_3_hi",  64'(bus.result_hi), 64'd0);

        // Start held high: one done every 34 cycles
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 1'b0; bus.op_a = 32'd5; bus.op_b = 32'd5;
        pulses = 0; last = -1;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (bus.done) begin
                if (last >= 0) check("b2b_gap", 64'(c - last), 64'd34);
                last = c;
                pulses++;
            end
        end
        check("b2b_pulses", 64'(pulses >= 3), 64'd1);
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (40) @(posedge clk);

        // start with abort in IDLE
        #1 bus.start = 1'b1; bus.abort = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("sa_stall", 64'(bus.stall), 64'd0);
            check("sa_busy",  64'(bus.busy),  64'd0);
        end
        @(posedge clk); #1 bus.start = 1'b0; bus.abort = 1'b0;

        // Randomized traffic, checked every cycle by the compare process
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            bus.start = ($urandom_range(0, 3) != 0);
            bus.op    = $urandom_range(0, 1) == 1;
            bus.abort = ($urandom_range(0, 63) == 0);
            bus.op_a  = $urandom;
            bus.op_b  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 3) == 0) bus.op_b = 32'($urandom_range(1, 255));
        end
        @(posedge clk); #1 bus.start = 1'b0; bus.abort = 1'b0;
        repeat (40) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/ex_muldiv_seq.md
EX_MULDIV_SEQ -- requirements
Module: ex_muldiv_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 rising-edge clock; rst input 1 asynchronous active-low reset.
REQ-002 The block SHALL provide the following ports:
- start  input  1  request from EX stage; sampled only in IDLE.
- op  input  1  0 = unsigned multiply, 1 = unsigned divide.
- abort  input  1  pipeline flush; cancels operation.
- op_a  input  32  multiplicand / dividend (EX rs data).
- op_b  input  32  multiplier / divisor (EX rt data or immediate).
- busy  output  1  high in RUN and DONE.
- stall  output  1  freeze IF/ID/EX pipeline registers.
- done  output  1  one-cycle completion pulse.
- result_lo  output  32  product[31:0] / quotient.
- result_hi  output  32  product[63:32] / remainder.
- div_zero  output  1  last divide had op_b == 0.

Function
REQ-003 The FSM SHALL have exactly three states, IDLE, RUN and DONE, with the following transitions:
- IDLE->RUN on start & !abort.
- RUN->DONE after 32 iterations.
- DONE->IDLE unconditionally.
REQ-004 On start acceptance, the block SHALL latch op, op_a and op_b and clear a 6-bit iteration counter; operand changes afterwards SHALL have no effect.
REQ-005 Multiply SHALL be shift-add, one bit of op_b per RUN cycle (LSB first), producing an exact 64-bit unsigned product.
REQ-006 Divide SHALL be restoring, one quotient bit per RUN cycle (MSB first): quotient goes to result_lo and remainder to result_hi.
REQ-007 Latency SHALL be fixed: start sampled at edge E0, RUN occupies the cycles after E0..E31, and done is high for exactly the one cycle after E32 (DONE state).
REQ-008 stall SHALL be high combinationally in IDLE when start & !abort, and throughout RUN; it SHALL be low in DONE so EX advances with the result.
REQ-009 result_lo and result_hi SHALL update only on entry to DONE and hold until the next completed operation; intermediate values SHALL NOT be visible.
REQ-010 Divide with op_b == 0 SHALL go IDLE->DONE directly (latency 1) with result_lo = 32'hFFFFFFFF, result_hi = latched op_a and div_zero = 1.
REQ-011 div_zero SHALL update at every DONE entry and hold otherwise.
REQ-012 start while busy SHALL be ignored; there is no queueing.
REQ-013 abort in RUN SHALL return to IDLE at the next edge, with no done, results unchanged and stall low in that IDLE cycle unless a new start is presented.
REQ-014 abort in DONE SHALL have no effect: done still pulses and the results update.
REQ-015 abort and start together in IDLE: abort SHALL win and the block SHALL stay in IDLE.
REQ-016 The counter SHALL count 0..31 and SHALL NOT wrap; the transition to DONE SHALL occur at count 31.

Reset
REQ-017 rst low SHALL asynchronously force the state to IDLE, the counter to 0, and busy, stall, done and div_zero to 0, with result_lo = result_hi = 0.
REQ-018 Reset asserted mid-RUN SHALL discard the operation; the first start after rst deassertion SHALL behave per REQ-007.

Configuration
REQ-019 The divider SHALL be compiled in or out by the macro MULDIV_DIV_EN.
- Defined: divide behaves per REQ-006/REQ-010.
- Undefined: no divider logic is present; op = 1 goes IDLE->DONE (latency 1) with result_lo = result_hi = 0 and div_zero = 0; multiply is unaffected.

Verification
REQ-020 Multiply 32'hFFFFFFFF x 32'hFFFFFFFF: done exactly 33 cycles after the start edge, result_hi = 32'hFFFFFFFE, result_lo = 32'h00000001, stall high for 32 cycles.
REQ-021 Divide 100 / 7: quotient 14, remainder 2, div_zero = 0; divide 5 / 0: done after 1 cycle, result_lo = 32'hFFFFFFFF, result_hi = 5, div_zero = 1.
REQ-022 Multiply 3 x 4 with abort pulsed in RUN cycle 10: no done, results hold the prior values, and a new start of 2 x 2 then yields result_lo = 4.
REQ-023 rst pulsed low mid-divide: all outputs 0 immediately, and a following 9 / 3 completes with quotient 3, remainder 0.
REQ-024 start held high continuously: back-to-back operations with one done pulse per 34 cycles; start and abort together in IDLE: no stall, no busy.
REQ-025 Build with MULDIV_DIV_EN undefined: divide 100 / 7 gives done after 1 cycle with zero results; multiply 6 x 7 gives 42.
